// File: rtl/perf_event_counters.sv
// Bank of per-channel event counters with an IDLE/RUN/FROZEN gate and a registered read port.
// Optional feature: define PERF_CYCLE_CNT_EN to add a RUN-cycle counter at index NUM_CH.

module perf_cnt_lane #(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             ovf_d_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SAT_MODE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The read port captures post-edge values, so the next-state is what leaves the lane.
  assign cnt_d_o = cnt_d;
  assign ovf_d_o = ovf_d;
endmodule

module perf_event_counters #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  localparam int SEL_W   = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] evt_i,
  input  logic              rd_en_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_ovf_o,
  output logic              rd_valid_o,
  output logic              frozen_o
);
`ifdef PERF_CYCLE_CNT_EN
  localparam int NUM_TOT = NUM_CH + 1;
`else
  localparam int NUM_TOT = NUM_CH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_e;

  state_e                          state_q;
  logic                            frozen_q;
  logic                            evt_en, cyc_en;
  logic [NUM_TOT-1:0][CNT_W-1:0]   cnt_d;
  logic [NUM_TOT-1:0]              ovf_d;
  logic [CNT_W-1:0]                sel_cnt, rd_data_q;
  logic                            sel_ovf, rd_ovf_q, rd_valid_q;

  // Events also count on the start edge; the cycle counter only sees RUN-state cycles.
  assign evt_en = !clr_i && (state_q == S_RUN || (state_q == S_IDLE && start_i));
  assign cyc_en = !clr_i && (state_q == S_RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      frozen_q <= 1'b0;
    end else if (clr_i) begin
      state_q  <= S_IDLE;
      frozen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (start_i) state_q <= S_RUN;
        S_RUN:    if (halt_i) begin
                    state_q  <= S_FROZEN;
                    frozen_q <= 1'b1;
                  end
        S_FROZEN: state_q <= S_FROZEN;
        default: begin
          state_q  <= S_IDLE;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_TOT; i++) begin : g_lane
    logic inc;
    if (i < NUM_CH) begin : g_evt
      assign inc = evt_en & evt_i[i];
    end else begin : g_cyc
      assign inc = cyc_en;
    end
    perf_cnt_lane #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr_i),
      .inc_i   (inc),
      .cnt_d_o (cnt_d[i]),
      .ovf_d_o (ovf_d[i])
    );
  end

  // Unmatched selects fall through to zero.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_TOT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        sel_cnt = cnt_d[i];
        sel_ovf = ovf_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= sel_cnt;
        rd_ovf_q  <= sel_ovf;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign rd_valid_o = rd_valid_q;
  assign frozen_o   = frozen_q;
endmodule
